ysyx_22050019_rd_arbiter: RTL and testbench

- Two-master, one-slave read arbiter that shares the single AXI-style read bus (ar/r channels) between the icache miss port (master 0) and the dcache miss port (master 1).
- Sits between the cache refill ports and the memory/bus bridge.
- Carries one outstanding single-beat transaction at a time.
- Latches the grant for the whole ar→r transaction and routes the response back only to the granted master.

---
 rtl/ysyx_22050019_pkg.sv | 18 +
 rtl/ysyx_22050019_arb_sel.sv | 37 +++
 rtl/ysyx_22050019_rd_arbiter.sv | 115 +++++++++++
 tb/tb_ysyx_22050019_rd_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_pkg.sv
// Shared encodings for the two-master read arbiter: FSM states, master indices, response codes.
package ysyx_22050019_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_e;

  localparam logic       MST_ICACHE = 1'b0;
  localparam logic       MST_DCACHE = 1'b1;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ysyx_22050019_arb_sel.sv
// Combinational chooser between the icache and dcache requests.
// Fixed priority (dcache wins) by default; round-robin when YSYX_22050019_ARB_RR_EN is defined.
module ysyx_22050019_arb_sel
  import ysyx_22050019_pkg::*;
(
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last_grant,
  output logic [1:0] o_sel,
  output logic       o_idx
);

`ifndef YSYX_22050019_ARB_RR_EN
  logic w_unused;
  assign w_unused = i_last_grant;
`endif

  always_comb begin
    o_idx = MST_ICACHE;
    o_sel = 2'b00;
    if (i_valid0 && i_valid1) begin
`ifdef YSYX_22050019_ARB_RR_EN
      o_idx = ~i_last_grant;
`else
      o_idx = MST_DCACHE;
`endif
      o_sel = idx_to_onehot(o_idx);
    end else if (i_valid1) begin
      o_idx = MST_DCACHE;
      o_sel = 2'b10;
    end else if (i_valid0) begin
      o_idx = MST_ICACHE;
      o_sel = 2'b01;
    end
  end

endmodule

// File: rtl/ysyx_22050019_rd_arbiter.sv
// Two-master single-outstanding read arbiter sharing one ar/r bus between icache and dcache.
// Arbitration policy selected in ysyx_22050019_arb_sel via YSYX_22050019_ARB_RR_EN.
module ysyx_22050019_rd_arbiter
  import ysyx_22050019_pkg::*;
#(
  parameter int unsigned R_ADDR_WIDTH = 64,
  parameter int unsigned R_DATA_WIDTH = 64,
  parameter int unsigned RESP_WIDTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    s0_ar_valid_i,
  output logic                    s0_ar_ready_o,
  input  logic [R_ADDR_WIDTH-1:0] s0_ar_addr_i,
  output logic                    s0_r_valid_o,
  input  logic                    s0_r_ready_i,
  output logic [RESP_WIDTH-1:0]   s0_r_resp_o,
  output logic [R_DATA_WIDTH-1:0] s0_r_data_o,

  input  logic                    s1_ar_valid_i,
  output logic                    s1_ar_ready_o,
  input  logic [R_ADDR_WIDTH-1:0] s1_ar_addr_i,
  output logic                    s1_r_valid_o,
  input  logic                    s1_r_ready_i,
  output logic [RESP_WIDTH-1:0]   s1_r_resp_o,
  output logic [R_DATA_WIDTH-1:0] s1_r_data_o,

  output logic                    m_ar_valid_o,
  input  logic                    m_ar_ready_i,
  output logic [R_ADDR_WIDTH-1:0] m_ar_addr_o,
  input  logic                    m_r_valid_i,
  output logic                    m_r_ready_o,
  input  logic [RESP_WIDTH-1:0]   m_r_resp_i,
  input  logic [R_DATA_WIDTH-1:0] m_r_data_i,

  output logic                    grant_o,
  output logic                    busy_o
);

  state_e                  r_state;
  state_e                  w_state_next;
  logic                    r_grant;
  logic                    r_ar_valid;
  logic [R_ADDR_WIDTH-1:0] r_ar_addr;
  logic [1:0]              w_sel;
  logic                    w_sel_idx;
  logic                    w_ar_accept;

  // r_grant doubles as the round-robin history: it changes only on an accepted request.
  ysyx_22050019_arb_sel u_sel (
    .i_valid0     (s0_ar_valid_i),
    .i_valid1     (s1_ar_valid_i),
    .i_last_grant (r_grant),
    .o_sel        (w_sel),
    .o_idx        (w_sel_idx)
  );

  assign w_ar_accept  = (r_state == S_IDLE) && (w_sel != 2'b00);
  assign m_ar_valid_o = r_ar_valid;
  assign m_ar_addr_o  = r_ar_addr;
  assign grant_o      = r_grant;
  assign busy_o       = (r_state != S_IDLE);

  // Response payload is broadcast; only r_valid qualifies it.
  assign s0_r_data_o  = m_r_data_i;
  assign s1_r_data_o  = m_r_data_i;
  assign s0_r_resp_o  = m_r_resp_i;
  assign s1_r_resp_o  = m_r_resp_i;

  always_comb begin
    w_state_next  = r_state;
    s0_ar_ready_o = 1'b0;
    s1_ar_ready_o = 1'b0;
    s0_r_valid_o  = 1'b0;
    s1_r_valid_o  = 1'b0;
    m_r_ready_o   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        s0_ar_ready_o = w_sel[0];
        s1_ar_ready_o = w_sel[1];
        if (w_ar_accept) w_state_next = S_AR;
      end
      S_AR: begin
        if (r_ar_valid && m_ar_ready_i) w_state_next = S_R;
      end
      S_R: begin
        m_r_ready_o  = r_grant ? s1_r_ready_i : s0_r_ready_i;
        s0_r_valid_o = (r_grant == MST_ICACHE) && m_r_valid_i;
        s1_r_valid_o = (r_grant == MST_DCACHE) && m_r_valid_i;
        if (m_r_valid_i && m_r_ready_o) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_grant    <= MST_ICACHE;
      r_ar_valid <= 1'b0;
      r_ar_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_ar_accept) begin
        r_grant    <= w_sel_idx;
        r_ar_valid <= 1'b1;
        r_ar_addr  <= w_sel_idx ? s1_ar_addr_i : s0_ar_addr_i;
      end else if ((r_state == S_AR) && m_ar_ready_i) begin
        r_ar_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_rd_arbiter.sv
// Directed bench for the read arbiter: transaction-level model checked every cycle plus literals.
// Grant-order expectations follow YSYX_22050019_ARB_RR_EN when it is defined.
module tb_ysyx_22050019_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s0_ar_valid = 1'b0, s1_ar_valid = 1'b0;
  logic [63:0] s0_ar_addr = '0, s1_ar_addr = '0;
  logic        s0_r_ready = 1'b1, s1_r_ready = 1'b1;
  logic        m_ar_ready = 1'b0, m_r_valid = 1'b0;
  logic [1:0]  m_r_resp = 2'b00;
  logic [63:0] m_r_data = '0;

  logic        s0_ar_ready, s1_ar_ready, s0_r_valid, s1_r_valid;
  logic [1:0]  s0_r_resp, s1_r_resp;
  logic [63:0] s0_r_data, s1_r_data, m_ar_addr;
  logic        m_ar_valid, m_r_ready, grant, busy;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_22050019_rd_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .s0_ar_valid_i (s0_ar_valid),
    .s0_ar_ready_o (s0_ar_ready),
    .s0_ar_addr_i  (s0_ar_addr),
    .s0_r_valid_o  (s0_r_valid),
    .s0_r_ready_i  (s0_r_ready),
    .s0_r_resp_o   (s0_r_resp),
    .s0_r_data_o   (s0_r_data),
    .s1_ar_valid_i (s1_ar_valid),
    .s1_ar_ready_o (s1_ar_ready),
    .s1_ar_addr_i  (s1_ar_addr),
    .s1_r_valid_o  (s1_r_valid),
    .s1_r_ready_i  (s1_r_ready),
    .s1_r_resp_o   (s1_r_resp),
    .s1_r_data_o   (s1_r_data),
    .m_ar_valid_o  (m_ar_valid),
    .m_ar_ready_i  (m_ar_ready),
    .m_ar_addr_o   (m_ar_addr),
    .m_r_valid_i   (m_r_valid),
    .m_r_ready_o   (m_r_ready),
    .m_r_resp_i    (m_r_resp),
    .m_r_data_i    (m_r_data),
    .grant_o       (grant),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Transaction model: phase 0 = no transaction, 1 = address owed downstream, 2 = awaiting data.
  int          mdl_phase = 0;
  logic        mdl_owner = 1'b0;
  logic [63:0] mdl_addr  = '0;

  function automatic logic mdl_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
`ifdef YSYX_22050019_ARB_RR_EN
      return ~last;
`else
      return 1'b1;
`endif
    end
    return v1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_phase = 0;
      mdl_owner = 1'b0;
      mdl_addr  = '0;
    end else begin
      case (mdl_phase)
        0: if (s0_ar_valid || s1_ar_valid) begin
          mdl_owner = mdl_pick(s0_ar_valid, s1_ar_valid, mdl_owner);
          mdl_addr  = mdl_owner ? s1_ar_addr : s0_ar_addr;
          mdl_phase = 1;
        end
        1: if (m_ar_ready) mdl_phase = 2;
        default: if (m_r_valid && (mdl_owner ? s1_r_ready : s0_r_ready)) mdl_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic e_rdy0, e_rdy1, e_mv, e_rrdy, e_rv0, e_rv1, pick;
    e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_mv = 1'b0; e_rrdy = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
    if (mdl_phase == 0 && (s0_ar_valid || s1_ar_valid)) begin
      pick = mdl_pick(s0_ar_valid, s1_ar_valid, mdl_owner);
      e_rdy0 = !pick;
      e_rdy1 = pick;
    end
    if (mdl_phase == 1) e_mv = 1'b1;
    if (mdl_phase == 2) begin
      e_rrdy = mdl_owner ? s1_r_ready : s0_r_ready;
      e_rv0  = !mdl_owner && m_r_valid;
      e_rv1  = mdl_owner && m_r_valid;
    end
    chk("s0_ar_ready", 64'(s0_ar_ready), 64'(e_rdy0));
    chk("s1_ar_ready", 64'(s1_ar_ready), 64'(e_rdy1));
    chk("m_ar_valid", 64'(m_ar_valid), 64'(e_mv));
    chk("m_ar_addr", m_ar_addr, mdl_addr);
    chk("m_r_ready", 64'(m_r_ready), 64'(e_rrdy));
    chk("s0_r_valid", 64'(s0_r_valid), 64'(e_rv0));
    chk("s1_r_valid", 64'(s1_r_valid), 64'(e_rv1));
    chk("grant", 64'(grant), 64'(mdl_owner));
    chk("busy", 64'(busy), 64'(mdl_phase != 0));
    if (e_rv0) chk("s0_r_payload", {s0_r_data[61:0], s0_r_resp}, {m_r_data[61:0], m_r_resp});
    if (e_rv1) chk("s1_r_payload", {s1_r_data[61:0], s1_r_resp}, {m_r_data[61:0], m_r_resp});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered in the address phase; completes one transaction and returns in idle.
  task automatic serve(input logic [63:0] data, input logic [1:0] resp);
    m_ar_ready = 1'b1;
    cyc();
    m_ar_ready = 1'b0;
    m_r_valid  = 1'b1;
    m_r_data   = data;
    m_r_resp   = resp;
    cyc();
    m_r_valid  = 1'b0;
  endtask

  logic [5:0] exp_g;

  initial begin
`ifdef YSYX_22050019_ARB_RR_EN
    exp_g = 6'b010101;
`else
    exp_g = 6'b111111;
`endif
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();

    // Lone icache request.
    s0_ar_valid = 1'b1;
    s0_ar_addr  = 64'h8000_0000;
    #1 chk("t1_s0_ready", 64'(s0_ar_ready), 64'd1);
    cyc();
    s0_ar_valid = 1'b0;
    #1 chk("t1_addr", m_ar_addr, 64'h8000_0000);
    chk("t1_m_ar_valid", 64'(m_ar_valid), 64'd1);
    m_ar_ready = 1'b1;
    cyc();
    m_ar_ready = 1'b0;
    m_r_valid  = 1'b1;
    m_r_data   = 64'hDEAD_BEEF_0000_0001;
    #1 chk("t1_s0_r_valid", 64'(s0_r_valid), 64'd1);
    chk("t1_s1_r_valid", 64'(s1_r_valid), 64'd0);
    chk("t1_s0_r_data", s0_r_data, 64'hDEAD_BEEF_0000_0001);
    cyc();
    m_r_valid = 1'b0;
    #1 chk("t1_idle", 64'(busy), 64'd0);

    // Simultaneous requests: dcache first, icache request kept and served next.
    s0_ar_valid = 1'b1; s0_ar_addr = 64'h100;
    s1_ar_valid = 1'b1; s1_ar_addr = 64'h200;
    cyc();
    s1_ar_valid = 1'b0;
    #1 chk("t2_first_addr", m_ar_addr, 64'h200);
    chk("t2_first_grant", 64'(grant), 64'd1);
    serve(64'h2, 2'b00);
    cyc();
    s0_ar_valid = 1'b0;
    #1 chk("t2_second_addr", m_ar_addr, 64'h100);
    chk("t2_second_grant", 64'(grant), 64'd0);
    serve(64'h1, 2'b00);

    // Continuous contention for six transactions.
    s0_ar_valid = 1'b1; s0_ar_addr = 64'h300;
    s1_ar_valid = 1'b1; s1_ar_addr = 64'h400;
    for (int i = 0; i < 6; i++) begin
      cyc();
      #1 chk("t3_grant_seq", 64'(grant), 64'(exp_g[i]));
      if (i == 5) begin
        s0_ar_valid = 1'b0;
        s1_ar_valid = 1'b0;
      end
      serve(64'(i), 2'b00);
    end

    // Downstream address stall then icache response back-pressure.
    s0_ar_valid = 1'b1; s0_ar_addr = 64'h500;
    cyc();
    s0_ar_valid = 1'b0;
    s1_ar_valid = 1'b1; s1_ar_addr = 64'h600;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_stall_addr", m_ar_addr, 64'h500);
      chk("t4_stall_valid", 64'(m_ar_valid), 64'd1);
      chk("t4_stall_rdy", {62'd0, s0_ar_ready, s1_ar_ready}, 64'd0);
      chk("t4_stall_busy", 64'(busy), 64'd1);
      cyc();
    end
    m_ar_ready = 1'b1;
    cyc();
    m_ar_ready = 1'b0;
    s1_ar_valid = 1'b0;
    m_r_valid  = 1'b1;
    m_r_data   = 64'h55;
    s0_r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_r_bp", 64'(m_r_ready), 64'd0);
      cyc();
    end
    s0_r_ready = 1'b1;
    #1 chk("t4_r_go", 64'(m_r_ready), 64'd1);
    cyc();
    m_r_valid = 1'b0;

    // Error response forwarded untouched.
    s1_ar_valid = 1'b1; s1_ar_addr = 64'h700;
    cyc();
    s1_ar_valid = 1'b0;
    m_ar_ready  = 1'b1;
    cyc();
    m_ar_ready = 1'b0;
    m_r_valid  = 1'b1;
    m_r_resp   = 2'b10;
    #1 chk("t5_resp", 64'(s1_r_resp), 64'h2);
    chk("t5_s1_valid", 64'(s1_r_valid), 64'd1);
    cyc();
    m_r_valid = 1'b0;
    m_r_resp  = 2'b00;
    #1 chk("t5_idle", 64'(busy), 64'd0);

    // Asynchronous reset while waiting for data.
    s0_ar_valid = 1'b1; s0_ar_addr = 64'h800;
    cyc();
    s0_ar_valid = 1'b0;
    m_ar_ready  = 1'b1;
    cyc();
    m_ar_ready = 1'b0;
    #1 chk("t6_in_r", 64'(busy), 64'd1);
    #1 rst = 1'b0;
    #1 chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_grant", 64'(grant), 64'd0);
    chk("t6_addr", m_ar_addr, 64'd0);
    chk("t6_m_r_ready", 64'(m_r_ready), 64'd0);
    cyc();
    rst = 1'b1;
    s0_ar_valid = 1'b1; s0_ar_addr = 64'h900;
    #1 chk("t6_rerdy", 64'(s0_ar_ready), 64'd1);
    cyc();
    s0_ar_valid = 1'b0;
    #1 chk("t6_readdr", m_ar_addr, 64'h900);
    serve(64'h9, 2'b00);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
